// File: rtl/jt51_timer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jt51_timer_bank                                               |
// | Purpose  : NTIMERS up-counting reloadable timers sharing one prescaler,  |
// |            with sticky per-timer flags, IRQ enables, a combined active-  |
// |            low interrupt and a status byte for the host read path.       |
// |            Timer 0 counts every sample tick; timers 1.. count once per   |
// |            2^PRE_W ticks. All state moves only on cen.                   |
// | Ports    : clk, rst_n (async, active-low), cen, tick                     |
// |            value    - reload values, timer i at [i*W +: W]               |
// |            load     - run level; rising edge reloads, low freezes        |
// |            irq_en   - per-timer flag/IRQ enable                          |
// |            clr_flag - per-timer flag clear (a same-cycle set wins)       |
// |            flags    - sticky overflow flags                              |
// |            overflow - one-cen-period overflow strobes                    |
// |            irq_n    - ~|(flags & irq_en)                                 |
// |            status   - flags zero-extended to 8 bits                      |
// | Option   : JT51_TIMER_CSM_EN adds csm input and keyon_csm output, a      |
// |            one-cen-period pulse on each timer 0 overflow while csm=1.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module jt51_timer_bank #(
    parameter int NTIMERS = 2,
    parameter int W       = 10,
    parameter int PRE_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic                 tick,
    input  logic [NTIMERS*W-1:0] value,
    input  logic [NTIMERS-1:0]   load,
    input  logic [NTIMERS-1:0]   irq_en,
    input  logic [NTIMERS-1:0]   clr_flag,
    output logic [NTIMERS-1:0]   flags,
    output logic [NTIMERS-1:0]   overflow,
    output logic                 irq_n,
    output logic [7:0]           status
`ifdef JT51_TIMER_CSM_EN
    ,
    input  logic                 csm,
    output logic                 keyon_csm
`endif
);

    localparam logic [W-1:0]     C_CNT_MAX = '1;
    localparam logic [W-1:0]     C_CNT_ONE = W'(1);
    localparam logic [PRE_W-1:0] C_PRE_MAX = '1;
    localparam logic [PRE_W-1:0] C_PRE_ONE = PRE_W'(1);

    logic [NTIMERS-1:0] r_load_l;
    logic [PRE_W-1:0]   r_pre;
    logic [W-1:0]       r_cnt [NTIMERS];
    logic [NTIMERS-1:0] r_flags;
    logic [NTIMERS-1:0] r_overflow;

    logic               w_pre_tc;
    logic [NTIMERS-1:0] w_edge;
    logic [NTIMERS-1:0] w_adv;
    logic [NTIMERS-1:0] w_wrap;
    logic [NTIMERS-1:0] w_flags_nxt;
    logic [W-1:0]       w_cnt_nxt [NTIMERS];
    logic [7:0]         w_status;

    // Prescaler terminal count: the tick on which the prescaler wraps.
    assign w_pre_tc = tick & (r_pre == C_PRE_MAX);
    assign w_edge   = load & ~r_load_l;

    genvar gi;
    generate
        for (gi = 0; gi < NTIMERS; gi++) begin : g_timer
            logic w_step;

            if (gi == 0) begin : g_base
                assign w_step = tick;
            end else begin : g_scaled
                assign w_step = w_pre_tc;
            end

            // A load edge owns the cycle: the same-cycle tick is dropped.
            assign w_adv[gi]  = w_step & load[gi] & ~w_edge[gi];
            assign w_wrap[gi] = w_adv[gi] & (r_cnt[gi] == C_CNT_MAX);

            assign w_cnt_nxt[gi] = (w_edge[gi] | w_wrap[gi]) ? value[gi*W +: W] :
                                   w_adv[gi]                 ? r_cnt[gi] + C_CNT_ONE :
                                                               r_cnt[gi];

            // Set has priority over clear so an overflow is never lost.
            assign w_flags_nxt[gi] = (w_wrap[gi] & irq_en[gi]) |
                                     (r_flags[gi] & ~clr_flag[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_l   <= '0;
            r_pre      <= '0;
            r_flags    <= '0;
            r_overflow <= '0;
            for (int i = 0; i < NTIMERS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (cen) begin
            r_load_l   <= load;
            r_flags    <= w_flags_nxt;
            r_overflow <= w_wrap;
            if (tick) begin
                r_pre <= r_pre + C_PRE_ONE;
            end
            for (int i = 0; i < NTIMERS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    always_comb begin
        w_status              = '0;
        w_status[NTIMERS-1:0] = r_flags;
    end

    assign flags    = r_flags;
    assign overflow = r_overflow;
    assign irq_n    = ~|(r_flags & irq_en);
    assign status   = w_status;

`ifdef JT51_TIMER_CSM_EN
    logic r_keyon_csm;

    // Independent of irq_en[0]: CSM key-on follows the raw overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keyon_csm <= 1'b0;
        end else if (cen) begin
            r_keyon_csm <= w_wrap[0] & csm;
        end
    end

    assign keyon_csm = r_keyon_csm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt51_timer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jt51_timer_bank                                            |
// | Purpose  : Self-checking bench for jt51_timer_bank. A reference model    |
// |            tracks, per timer, the number of advances left before the     |
// |            next overflow, plus a running sample-tick count for the       |
// |            prescaler, and predicts every registered output each cycle.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_jt51_timer_bank;

    localparam int NT     = 2;
    localparam int W      = 10;
    localparam int PRE_W  = 4;
    localparam int C_FULL = 1 << W;
    localparam int C_PRE  = 1 << PRE_W;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          cen      = 1'b0;
    logic          tick     = 1'b0;
    logic [NT*W-1:0] value  = '0;
    logic [NT-1:0] load     = '0;
    logic [NT-1:0] irq_en   = '0;
    logic [NT-1:0] clr_flag = '0;
    logic [NT-1:0] flags;
    logic [NT-1:0] overflow;
    logic          irq_n;
    logic [7:0]    status;
`ifdef JT51_TIMER_CSM_EN
    logic          csm = 1'b0;
    logic          keyon_csm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_rem [NT];
    bit [NT-1:0] m_load_l;
    bit [NT-1:0] m_flags;
    bit [NT-1:0] m_ovf;
    int          m_ticks;
    bit          m_keyon;

    jt51_timer_bank #(.NTIMERS(NT), .W(W), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .tick     (tick),
        .value    (value),
        .load     (load),
        .irq_en   (irq_en),
        .clr_flag (clr_flag),
        .flags    (flags),
        .overflow (overflow),
        .irq_n    (irq_n),
        .status   (status)
`ifdef JT51_TIMER_CSM_EN
        ,
        .csm      (csm),
        .keyon_csm(keyon_csm)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) m_rem[i] = C_FULL;
        m_load_l = '0;
        m_flags  = '0;
        m_ovf    = '0;
        m_ticks  = 0;
        m_keyon  = 1'b0;
    endtask

    // One cen period of the timer rules, using the inputs currently applied.
    task automatic model_cycle();
        bit          tc;
        bit [NT-1:0] ovf_n;
        int          val;
        if (!cen) return;
        tc    = tick && ((m_ticks % C_PRE) == C_PRE - 1);
        ovf_n = '0;
        for (int i = 0; i < NT; i++) begin
            val = int'(value[i*W +: W]);
            if (load[i] && !m_load_l[i]) begin
                m_rem[i] = C_FULL - val;
            end else if (load[i] && (i == 0 ? tick : tc)) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    ovf_n[i] = 1'b1;
                    m_rem[i] = C_FULL - val;
                end
            end
            if (ovf_n[i] && irq_en[i]) m_flags[i] = 1'b1;
            else if (clr_flag[i])      m_flags[i] = 1'b0;
            m_load_l[i] = load[i];
        end
        if (tick) m_ticks++;
        m_ovf = ovf_n;
`ifdef JT51_TIMER_CSM_EN
        m_keyon = ovf_n[0] && csm;
`endif
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".flags"},    32'(flags),    32'(m_flags));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".irq_n"},    32'(irq_n),    32'(~|(m_flags & irq_en)));
        check({tag, ".status"},   32'(status),   32'({{(8-NT){1'b0}}, m_flags}));
`ifdef JT51_TIMER_CSM_EN
        check({tag, ".keyon_csm"}, 32'(keyon_csm), 32'(m_keyon));
`endif
    endtask

    task automatic step(input string tag);
        if (!rst_n) model_reset();
        else        model_cycle();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Step until the model predicts an overflow on timer 0, at most 'bound' cycles.
    task automatic sync_ovf0(input string tag, input int bound);
        int n;
        n = 0;
        do begin
            step(tag);
            n++;
        end while (!m_ovf[0] && n < bound);
        check({tag, ".sync"}, 32'(m_ovf[0]), 32'd1);
    endtask

    // Count steps until overflow[0] is observed on the DUT (bounded).
    task automatic steps_to_ovf0(input string tag, input int bound, output int n);
        n = 0;
        do begin
            step(tag);
            n++;
        end while (overflow[0] !== 1'b1 && n < bound);
    endtask

    initial begin
        int first0, first1, cnt, n;
        first0 = 0;
        first1 = 0;

        // Reset state
        model_reset();
        repeat (2) step("reset");

        // Timer 0 period 4, timer 1 period 32 ticks, both started from reset
        cen    = 1'b1;
        tick   = 1'b1;
        irq_en = 2'b11;
        value  = {10'd1022, 10'd1020};
        load   = 2'b11;
`ifdef JT51_TIMER_CSM_EN
        csm    = 1'b1;
`endif
        rst_n  = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            step("run");
            if (overflow[0] === 1'b1 && first0 == 0) first0 = k;
            if (overflow[1] === 1'b1 && first1 == 0) first1 = k;
        end
        check("first_ovf0", 32'(first0), 32'd5);
        check("first_ovf1", 32'(first1), 32'd32);
        check("irq_n_set", 32'(irq_n), 32'd0);

        // Flag clear, then a clear colliding with an overflow
        irq_en = 2'b01;
        load[0] = 1'b0;
        step("stop0");
        load[0] = 1'b1;
        step("edge0");
        step("cnt1021");
        clr_flag[0] = 1'b1;
        step("clr");
        check("clr.flag0", 32'(flags[0]), 32'd0);
        check("clr.irq_n", 32'(irq_n), 32'd1);
        clr_flag[0] = 1'b0;
        step("cnt1023");
        clr_flag[0] = 1'b1;
        step("clr_vs_set");
        check("clr_vs_set.ovf0",  32'(overflow[0]), 32'd1);
        check("clr_vs_set.flag0", 32'(flags[0]), 32'd1);
        clr_flag[0] = 1'b0;

        // Overflows with irq_en low leave flags clear
        clr_flag = 2'b11;
        step("clr_all");
        clr_flag = 2'b00;
        irq_en   = 2'b00;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step("masked");
            if (overflow[0] === 1'b1) cnt++;
        end
        check("masked.pulses", 32'(cnt), 32'd3);
        check("masked.flag0", 32'(flags[0]), 32'd0);

        // Stop at cnt=1022 for 10 ticks, then restart from a fresh reload
        irq_en = 2'b01;
        sync_ovf0("sync_stop", 10);
        step("to1021");
        step("to1022");
        load[0] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step("stopped");
            if (overflow[0] === 1'b1) cnt++;
        end
        check("stopped.pulses", 32'(cnt), 32'd0);
        load[0] = 1'b1;
        step("restart_edge");
        steps_to_ovf0("restart", 10, n);
        check("restart.latency", 32'(n), 32'd4);

        // Asynchronous reset mid-count (cnt=1021), load held high through it
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        repeat (2) step("rst_hold");
        rst_n = 1'b1;
        steps_to_ovf0("after_rst", 10, n);
        check("after_rst.latency", 32'(n), 32'd5);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            cen  = ($urandom_range(0, 9) < 8);
            tick = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NT; i++) begin
                if ($urandom_range(0, 19) == 0) load[i] = ~load[i];
                if ($urandom_range(0, 9) == 0)
                    value[i*W +: W] = W'(C_FULL - int'($urandom_range(1, 12)));
            end
            if ($urandom_range(0, 15) == 0) irq_en = NT'($urandom);
            clr_flag = ($urandom_range(0, 9) == 0) ? NT'($urandom) : '0;
`ifdef JT51_TIMER_CSM_EN
            csm = 1'($urandom);
`endif
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt51_timer_bank.md
Name: jt51_timer_bank

Overview:
Parametrised timer bank: the successor to the fixed two-timer (A/B) unit in the FM core. Provides NTIMERS up-counting reloadable timers with a shared prescaler, per-timer flags and IRQ enables, a combined irq_n, and a status byte for the host read path. It sits beside the register map. It is clocked on the same cen strobe as the rest of the sound core, and counts on the per-sample tick.

Parameters:
NTIMERS, 2, number of timers (1..8).
W, 10, counter/load width shared by all timers.
PRE_W, 4, prescaler width; timers with index>=1 advance once every 2^PRE_W ticks.

Ports:
clk  in  1  main clock
rst_n  in  1  reset, asynchronous, active-low
cen  in  1  clock enable; all state updates only when cen=1
tick  in  1  sample strobe (one cen period per output sample)
value  in  NTIMERS*W  reload values, timer i at [i*W +: W]
load  in  NTIMERS  run level per timer; rising edge loads and starts, low stops
irq_en  in  NTIMERS  per-timer flag/IRQ enable
clr_flag  in  NTIMERS  flag clear, sampled on cen
flags  out  NTIMERS  sticky overflow flags
overflow  out  NTIMERS  overflow strobe, one cen period
irq_n  out  1  ~|(flags & irq_en)
status  out  8  {busy_in passthrough 0, 7-NTIMERS zeros.., flags} zero-extended flags, MSB=0

Behaviour:
- Reset (rst_n=0, async): counters=0, prescaler=0, load_l=0, flags=0, overflow=0, irq_n=1, status=0. Reset mid-count discards all state; after release a timer whose load is still high restarts only on a new rising edge of load (load_l is cleared, so the first cen sees an edge and reloads).
- load_l[i] registers load[i] on every cen; edge = load & ~load_l.
- Edge on cen: cnt[i]<=value[i]. The edge takes precedence over a same-cycle tick, which is ignored for that timer.
- Prescaler: PRE_W-bit counter increments on cen&tick and wraps. pre_tc = tick & (pre==all-ones).
- Advance: timer 0 on cen&tick; timer i>=1 on cen&pre_tc; only while load[i]=1 and no edge.
- On advance: if cnt==2^W-1 then cnt<=value[i], overflow[i]<=1, flags[i]<=1 when irq_en[i]; else cnt<=cnt+1.
- Overflow period = 2^W - value ticks (timer 0). For timers i>=1 it is (2^W - value)*2^PRE_W ticks after prescaler alignment.
- overflow[i] is registered and high for exactly one cen period, then cleared on the next cen.
- load low: counter frozen (holds value). Flags hold. Rising edge again reloads.
- clr_flag[i] on cen clears flags[i]. A same-cycle set wins over the clear.
- irq_en low: flag never set by new overflows. An already set flag is held but masked from irq_n.
- irq_n is combinational from registered flags/irq_en (no sync; caller handles it).
- value change while running: takes effect only at next reload or edge.
- cen low: all registers hold. tick ignored.

Optional Feature:
Macro JT51_TIMER_CSM_EN.
- Defined: adds input csm (1) and output keyon_csm (1). keyon_csm is registered and high for one cen period whenever overflow[0] is generated while csm=1. It is independent of irq_en[0]. Reset value is 0.
- Not defined: ports absent; no CSM logic.

Test Plan:
- W=10, value0=1020, load0 rising, tick every cen -> overflow[0] after 4 ticks, again every 4 ticks; irq_en0=1 -> flags[0]=1, irq_n=0.
- Timer 1, PRE_W=4, value1=1022, load from reset -> first overflow[1] at tick 32, period 32 ticks.
- flags[0]=1, clr_flag0 pulse -> flags[0]=0, irq_n=1. clr_flag0 asserted in the same cen as an overflow -> flags[0] stays 1.
- irq_en0=0, overflows -> overflow[0] pulses, flags[0]=0, irq_n=1.
- load0 dropped at cnt=1022 for 10 ticks, then re-raised -> cnt reloads value0; no overflow during stop.
- rst_n asserted mid-count (cnt=1021) -> all outputs 0/irq_n=1 immediately. With load0 held high after release, the timer reloads on the first cen; with CSM_EN and csm=1, keyon_csm pulses in the same cen period as each overflow[0].
